// File: rtl/pulse_width_meter.sv
// pulse_width_meter: measures pulse_in high time in clk_in cycles,
// saturating, with the result held under a valid/ack handshake.
//
// Ports:
//   clk_in    free-running clock
//   reset_n   async active-low reset
//   enable    arms the meter; low aborts a measurement
//   pulse_in  measured signal, synchronous to clk_in
//   ack       consumer accepts the held result
//   width     measured high time, stable while valid
//   valid     result available
//   overflow  result saturated
//   busy      measurement in progress
module pulse_width_meter #(
  parameter int COUNTER_WIDTH = 8
) (
  input  logic                     clk_in,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     pulse_in,
  input  logic                     ack,
  output logic [COUNTER_WIDTH-1:0] width,
  output logic                     valid,
  output logic                     overflow,
  output logic                     busy
);

  localparam logic [COUNTER_WIDTH-1:0] MAX = '1;
  localparam logic [COUNTER_WIDTH-1:0] ONE =
    COUNTER_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    HOLD
  } state_t;

  state_t                   state;
  logic [COUNTER_WIDTH-1:0] counter;
  logic                     pulse_latch;
  logic                     sat_flag;
  logic                     rise;

  assign rise = pulse_in & ~pulse_latch;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      counter     <= '0;
      width       <= '0;
      valid       <= 1'b0;
      overflow    <= 1'b0;
      busy        <= 1'b0;
      pulse_latch <= 1'b0;
      sat_flag    <= 1'b0;
    end else begin
      pulse_latch <= pulse_in;
      unique case (state)
        IDLE: begin
          if (enable && rise) begin
            counter  <= ONE;
            // a one-bit counter is already full on the first edge
            sat_flag <= (ONE == MAX);
            busy     <= 1'b1;
            state    <= MEASURE;
          end
        end
        MEASURE: begin
          if (!enable) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (pulse_in) begin
            if (counter != MAX) begin
              counter <= counter + ONE;
            end
            // flag as soon as the count reaches full scale
            if (counter >= MAX - ONE) begin
              sat_flag <= 1'b1;
            end
          end else begin
            width    <= counter;
            overflow <= sat_flag;
            valid    <= 1'b1;
            busy     <= 1'b0;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (ack) begin
            valid    <= 1'b0;
            overflow <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
